// File: rtl/sad_best_mv_tracker.sv
`default_nettype none
// sad_best_mv_tracker: per-partition minimum-cost and motion-vector tracker
// over a raster-scanned integer search window, with optional MV-cost weighting.
module sad_best_mv_tracker #(
  parameter int NUM_PART     = 7,
  parameter int SAD_W        = 16,
  parameter int SR_COLS      = 64,
  parameter int SR_ROWS      = 64,
  parameter int LAMBDA_SHIFT = 2,
  localparam int CW = $clog2(SR_COLS),
  localparam int RW = $clog2(SR_ROWS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cost_en,
  input  logic                         sad_valid,
  input  logic [NUM_PART*SAD_W-1:0]    sad_in,
  output logic                         busy,
  output logic                         done,
  output logic [CW-1:0]                search_column_count,
  output logic [RW-1:0]                search_row_count,
  output logic [NUM_PART*SAD_W-1:0]    best_cost,
  output logic [NUM_PART*(CW+1)-1:0]   best_mv_x,
  output logic [NUM_PART*(RW+1)-1:0]   best_mv_y
);
  localparam int AW = ((CW > RW) ? CW : RW) + 2;
  localparam int FW = SAD_W + AW + LAMBDA_SHIFT + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  state_t        state, state_next;
  logic          cost_en_q, first, done_q;
  logic          accept, last;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW:0]   mv_x_cur, abs_x;
  logic [RW:0]   mv_y_cur, abs_y;
  logic [FW-1:0] penalty;

  assign accept = sad_valid && (state == SEARCH) && !start;
  assign last   = accept && (col == CW'(SR_COLS - 1)) && (row == RW'(SR_ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state == SEARCH);
    if (start)     state_next = SEARCH;
    else if (last) state_next = IDLE;
  end

  // Counters wrap naturally to zero at the final candidate (power-of-two window).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      done_q    <= 1'b0;
      cost_en_q <= 1'b0;
      first     <= 1'b0;
    end else begin
      done_q <= last;
      if (start) begin
        col       <= '0;
        row       <= '0;
        cost_en_q <= cost_en;
        first     <= 1'b1;
      end else if (accept) begin
        first <= 1'b0;
        col   <= col + CW'(1);
        if (col == CW'(SR_COLS - 1)) row <= row + RW'(1);
      end
    end
  end

  assign done                = done_q;
  assign search_column_count = col;
  assign search_row_count    = row;

  assign mv_x_cur = {1'b0, col} - (CW+1)'(SR_COLS / 2);
  assign mv_y_cur = {1'b0, row} - (RW+1)'(SR_ROWS / 2);
  assign abs_x    = mv_x_cur[CW] ? -mv_x_cur : mv_x_cur;
  assign abs_y    = mv_y_cur[RW] ? -mv_y_cur : mv_y_cur;
  assign penalty  = (FW'(abs_x) + FW'(abs_y)) << LAMBDA_SHIFT;

  for (genvar k = 0; k < NUM_PART; k++) begin : g_ch
    logic [SAD_W-1:0] sad_k, cost_k, best_q;
    logic [FW-1:0]    sum_k;
    logic [CW:0]      mvx_q;
    logic [RW:0]      mvy_q;

    assign sad_k  = sad_in[k*SAD_W +: SAD_W];
    assign sum_k  = FW'(sad_k) + (cost_en_q ? penalty : '0);
    assign cost_k = (sum_k > FW'({SAD_W{1'b1}})) ? '1 : sum_k[SAD_W-1:0];

    // Strict less-than keeps the earliest raster position on ties.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        best_q <= '1;
        mvx_q  <= '0;
        mvy_q  <= '0;
      end else if (start) begin
        best_q <= '1;
        mvx_q  <= '0;
        mvy_q  <= '0;
      end else if (accept && (first || (cost_k < best_q))) begin
        best_q <= cost_k;
        mvx_q  <= mv_x_cur;
        mvy_q  <= mv_y_cur;
      end
    end

    assign best_cost[k*SAD_W +: SAD_W]  = best_q;
    assign best_mv_x[k*(CW+1) +: CW+1] = mvx_q;
    assign best_mv_y[k*(RW+1) +: RW+1] = mvy_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_sad_best_mv_tracker.sv
`default_nettype none
// tb_sad_best_mv_tracker: directed self-checking bench, 2 channels, 4x4 window.
module tb_sad_best_mv_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cost_en = 1'b0;
  logic        sad_valid = 1'b0;
  logic [15:0] sad_in = '0;
  logic        busy, done;
  logic [1:0]  col, row;
  logic [15:0] best_cost;
  logic [5:0]  best_mv_x, best_mv_y;

  int n_checks = 0;
  int n_pass   = 0;

  sad_best_mv_tracker #(
    .NUM_PART(2), .SAD_W(8), .SR_COLS(4), .SR_ROWS(4), .LAMBDA_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cost_en(cost_en),
    .sad_valid(sad_valid), .sad_in(sad_in), .busy(busy), .done(done),
    .search_column_count(col), .search_row_count(row),
    .best_cost(best_cost), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: directed min pattern; 1: all 7; 2: all 250; 3: index+30
  function automatic logic [15:0] sad_vec(input int mode, input int i);
    logic [7:0] a, b;
    case (mode)
      0: begin a = (i == 6) ? 8'd10 : 8'd50; b = 8'(200 - 4 * i); end
      1: begin a = 8'd7;   b = 8'd7;   end
      2: begin a = 8'd250; b = 8'd250; end
      default: begin a = 8'(i + 30); b = 8'(i + 30); end
    endcase
    return {b, a};
  endfunction

  task automatic do_start(input logic ce);
    start = 1'b1; cost_en = ce;
    step();
    start = 1'b0; cost_en = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_cnt", 32'({row, col}), 32'd0);
    check("start_cost", 32'(best_cost), 32'hFFFF);
    check("start_mv", 32'({best_mv_y, best_mv_x}), 32'd0);
  endtask

  task automatic feed(input int mode, input int i);
    sad_valid = 1'b1; sad_in = sad_vec(mode, i);
    step();
    sad_valid = 1'b0;
  endtask

  task automatic run_search(input int mode, input bit stall);
    for (int i = 0; i < 16; i++) begin
      if (stall) begin
        sad_in = 16'h0101;
        step();
        if (i == 5) check("stall_cnt", 32'({row, col}), 32'd5);
      end
      feed(mode, i);
      if (i == 14) check("pre_done", 32'({busy, done}), 32'b10);
    end
    check("done_pulse", 32'({busy, done}), 32'b01);
    check("done_cnt", 32'({row, col}), 32'd0);
  endtask

  initial begin
    bit saw_done;
    // 1. reset values
    #12;
    check("rst_ctrl", 32'({busy, done, row, col}), 32'd0);
    check("rst_cost", 32'(best_cost), 32'hFFFF);
    check("rst_mv", 32'({best_mv_y, best_mv_x}), 32'd0);
    @(negedge clk); rst = 1'b0;
    step();

    // 2. directed minimum
    do_start(1'b0);
    run_search(0, 1'b0);
    check("t2_cost", 32'(best_cost), {16'd0, 8'd140, 8'd10});
    check("t2_mvx", 32'(best_mv_x), {26'd0, 3'b001, 3'b000});
    check("t2_mvy", 32'(best_mv_y), {26'd0, 3'b001, 3'b111});

    // 3. ties keep first; start issued in the done cycle
    do_start(1'b0);
    run_search(1, 1'b0);
    check("t3_cost", 32'(best_cost), {16'd0, 8'd7, 8'd7});
    check("t3_mv", 32'({best_mv_y, best_mv_x}), {20'd0, 12'b110110_110110});

    // 4. MV cost with saturation
    do_start(1'b1);
    feed(2, 0);
    check("t4_sat", 32'(best_cost), {16'd0, 8'd255, 8'd255});
    for (int i = 1; i < 16; i++) feed(2, i);
    check("t4_done", 32'(done), 32'd1);
    check("t4_cost", 32'(best_cost), {16'd0, 8'd250, 8'd250});
    check("t4_mv", 32'({best_mv_y, best_mv_x}), 32'd0);

    // 5. stalls, then sad_valid while idle
    do_start(1'b0);
    run_search(3, 1'b1);
    check("t5_cost", 32'(best_cost), {16'd0, 8'd30, 8'd30});
    check("t5_mv", 32'({best_mv_y, best_mv_x}), {20'd0, 12'b110110_110110});
    step();
    check("t5_done_low", 32'(done), 32'd0);
    sad_valid = 1'b1; sad_in = 16'h0000;
    repeat (3) step();
    sad_valid = 1'b0;
    check("idle_ctrl", 32'({busy, done, row, col}), 32'd0);
    check("idle_cost", 32'(best_cost), {16'd0, 8'd30, 8'd30});

    // 6a. restart after 5 candidates; the candidate alongside start is dropped
    do_start(1'b0);
    for (int i = 0; i < 5; i++) feed(3, i);
    check("t6_cnt5", 32'({row, col}), 32'b0101);
    start = 1'b1; sad_valid = 1'b1; sad_in = 16'h0000;
    step();
    start = 1'b0; sad_valid = 1'b0;
    check("restart_cnt", 32'({row, col}), 32'd0);
    check("restart_cost", 32'(best_cost), 32'hFFFF);
    check("restart_busy", 32'(busy), 32'd1);
    run_search(0, 1'b0);
    check("t6_cost", 32'(best_cost), {16'd0, 8'd140, 8'd10});
    step();

    // 6b. asynchronous reset mid-search
    do_start(1'b0);
    for (int i = 0; i < 9; i++) feed(0, i);
    check("t6_cnt9", 32'({row, col}), 32'b1001);
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", 32'({busy, done, row, col}), 32'd0);
    check("arst_cost", 32'(best_cost), 32'hFFFF);
    check("arst_mv", 32'({best_mv_y, best_mv_x}), 32'd0);
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    sad_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    sad_valid = 1'b0;
    check("arst_no_done", 32'({saw_done, busy}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sad_best_mv_tracker.md
# sad_best_mv_tracker

Parametrised best-candidate tracker for the integer motion-estimation search layer. It consumes one vector of partition SADs per search position, one SAD per partition. For each partition it keeps the lowest cost and that candidate's motion vector over a raster-scanned search window. It sits directly downstream of the SAD tree and generalises the fixed 4x8…32x32 SAD outputs to NUM_PART channels, a configurable window size and an optional MV-cost mode.

## Interface
Parameters:
- NUM_PART, 7, number of partition channels compared in parallel
- SAD_W, 16, bits per SAD and per cost
- SR_COLS, 64, search positions per row (power of two, ≥2)
- SR_ROWS, 64, search rows (power of two, ≥2)
- LAMBDA_SHIFT, 2, MV-cost weight shift

Derived widths:
- CW = $clog2(SR_COLS)
- RW = $clog2(SR_ROWS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a new search and clears results
- cost_en  in  1  sampled at start; 1 = add MV cost to SAD
- sad_valid  in  1  sad_in holds the candidate at the current counters
- sad_in  in  NUM_PART*SAD_W  packed SADs, channel k at [k*SAD_W +: SAD_W]
- busy  out  1  search in progress
- done  out  1  one-cycle pulse, results final
- search_column_count  out  CW  column of the next expected candidate
- search_row_count  out  RW  row of the next expected candidate
- best_cost  out  NUM_PART*SAD_W  minimum cost per channel
- best_mv_x  out  NUM_PART*(CW+1)  signed, two's complement
- best_mv_y  out  NUM_PART*(RW+1)  signed, two's complement

## Operation
States:
- IDLE → SEARCH on start.
- SEARCH → IDLE on acceptance of the last candidate, with done pulsed.
- SEARCH → SEARCH on start (restart).

Start:
- Clears both counters.
- Sets every best_cost to all-ones and every MV to 0.
- Latches cost_en.
- Sets the internal first flag.

Candidate acceptance:
- A candidate is accepted when sad_valid=1, busy=1 and start=0.
- sad_valid in IDLE is ignored.
- start together with sad_valid: start wins and that candidate is dropped.

Per channel k, for an accepted candidate:
- mv_x = col − SR_COLS/2; mv_y = row − SR_ROWS/2.
- cost = sad_k + ((|mv_x|+|mv_y|) << LAMBDA_SHIFT) when cost_en is latched, else sad_k.
- The sum is formed at full width and saturated to 2^SAD_W−1.
- If first=1, or cost < best_cost_k (strict), load cost, mv_x and mv_y into channel k.
- Strict less-than means ties keep the earlier raster position.

Counters and completion:
- Counters advance only on acceptance.
- Column increments; at SR_COLS−1 it wraps to 0 and the row increments.
- Acceptance at (SR_COLS−1, SR_ROWS−1) ends the search: busy←0, done←1 for one cycle, counters←0.
- Results hold until the next start or rst.

Channels are fully independent; NUM_PART=1 is legal.

## Timing
- Reset values:
  - busy=0, done=0, counters=0.
  - best_cost = all ones in every channel.
  - best_mv_x = 0, best_mv_y = 0.
  - cost_en latch = 0, first = 0.
- rst mid-search aborts immediately to those values; no done is produced.
- Update latency is 1 cycle: a candidate accepted at edge N is reflected in best_* and the counters after edge N.
- busy rises the cycle after start is sampled.
- The first candidate may be presented in that same cycle (busy=1).
- Back-to-back sad_valid every cycle gives 1 candidate/clk; a full search takes SR_COLS*SR_ROWS accepted cycles.
- done is high exactly in the cycle after the final acceptance, and busy is already 0 in that cycle.
- best_* are valid while done=1 and afterwards.
- Gaps in sad_valid stall the counters; there is no timeout.
- start in the same cycle as done (IDLE) is legal and begins a new search.

## Test plan
Bench parameters: NUM_PART=2, SAD_W=8, SR_COLS=4, SR_ROWS=4, LAMBDA_SHIFT=2.

1. Reset only → all outputs at reset values; best_cost = 8'hFF per channel.
2. start, cost_en=0, then 16 consecutive candidates:
   - ch0 SAD = 50 everywhere except 10 at (col 2, row 1); ch1 = 200−4·index.
   - Required: done in the cycle after the 16th acceptance.
   - ch0: cost 10, mv (0,−1).
   - ch1: cost 140, mv (1,1).
3. All SADs = 7, cost_en=0 → ties keep the first candidate: cost 7, mv (−2,−2) on both channels.
4. cost_en=1, all SADs = 250 → cost at (0,0) saturates to 255.
   - The minimum is found at col 2, row 2: 250+0 = 250.
   - Required: best_cost 250, mv (0,0).
5. Stalls and ignored inputs:
   - sad_valid toggled 1/0 → counters advance only on 1s; done after the 16th acceptance.
   - sad_valid=1 while idle → no change.
6. Restart and reset:
   - start asserted after 5 candidates → counters return to 0 and best_cost to FF; 16 more candidates are then required for done.
   - rst after 9 candidates → reset values, no done.
